// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch-timer.
// FSM encodings, seconds range and prescaler sizing.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_EXPIRED = 2'b11
  } sw_state_t;

  localparam int SEC_W = 6;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

  // Width of a counter spanning 0..div-1, never below one bit.
  function automatic int presc_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/stopwatch_timer_core_tick_prescaler.sv
// One-second tick generator: counts clk cycles while enabled.
// tick is high on the terminal count and the counter wraps there.
module tick_prescaler
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = presc_width(TICK_DIV);
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_cnt;

  assign tick = en && (r_cnt == TERM);

  // Cycle counter: cleared on command, wraps on tick, else holds unless enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_timer_core.sv
// MM:SS up/down stopwatch-timer with preset load, expiry and lap capture.
// All counting advances only on the internal prescaler tick.
module stopwatch_timer_core
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int MIN_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             mode,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [5:0]       load_sec,
  input  logic             lap,
  output logic [MIN_W-1:0] minutes,
  output logic [5:0]       seconds,
  output logic [MIN_W-1:0] lap_min,
  output logic [5:0]       lap_sec,
  output logic             lap_valid,
  output logic [1:0]       status,
  output logic             expired,
  output logic             wrapped
);

  sw_state_t        r_state;
  logic [MIN_W-1:0] r_min;
  logic [5:0]       r_sec;
  logic [MIN_W-1:0] r_lap_min;
  logic [5:0]       r_lap_sec;
  logic             r_lap_valid;
  logic             r_expired;
  logic             r_wrapped;
  logic             r_mode;

  logic       w_tick;
  logic       w_run;
  logic       w_pclr;
  logic       w_zero;
  logic       w_one;
  logic [5:0] w_ld_sec;

  assign w_run    = (r_state == ST_RUNNING);
  assign w_zero   = (r_min == '0) && (r_sec == '0);
  assign w_one    = (r_min == '0) && (r_sec == 6'd1);
  assign w_ld_sec = (load_sec > SEC_MAX) ? SEC_MAX : load_sec;
  assign w_pclr   = clear
                  || ((r_state == ST_IDLE) && start)
                  || ((r_state == ST_PAUSED) && load);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .clk (clk),
    .rst (rst),
    .en  (w_run),
    .clr (w_pclr),
    .tick(w_tick)
  );

  // FSM, time counters, lap registers and pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_min       <= '0;
      r_sec       <= '0;
      r_lap_min   <= '0;
      r_lap_sec   <= '0;
      r_lap_valid <= 1'b0;
      r_expired   <= 1'b0;
      r_wrapped   <= 1'b0;
      r_mode      <= 1'b0;
    end else if (clear) begin
      r_state     <= ST_IDLE;
      r_min       <= '0;
      r_sec       <= '0;
      r_lap_min   <= '0;
      r_lap_sec   <= '0;
      r_lap_valid <= 1'b0;
      r_expired   <= 1'b0;
      r_wrapped   <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      r_wrapped <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (load) begin
            r_min <= load_min;
            r_sec <= w_ld_sec;
          end
          if (start && !(mode && w_zero)) begin
            r_state <= ST_RUNNING;
            r_mode  <= mode;
          end
        end
        ST_RUNNING: begin
          if (stop && !start) begin
            r_state <= ST_PAUSED;
          end else if (stop) begin
            r_state <= ST_PAUSED;
          end
          if (lap) begin
            r_lap_min   <= r_min;
            r_lap_sec   <= r_sec;
            r_lap_valid <= 1'b1;
          end
          if (w_tick) begin
            if (!r_mode) begin
              if (r_sec == SEC_MAX) begin
                r_sec <= '0;
                if (&r_min) begin
                  r_min     <= '0;
                  r_wrapped <= 1'b1;
                end else begin
                  r_min <= r_min + 1'b1;
                end
              end else begin
                r_sec <= r_sec + 1'b1;
              end
            end else if (w_zero || w_one) begin
              r_sec     <= '0;
              r_state   <= ST_EXPIRED;
              r_expired <= 1'b1;
            end else if (r_sec == '0) begin
              r_sec <= SEC_MAX;
              r_min <= r_min - 1'b1;
            end else begin
              r_sec <= r_sec - 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (start) begin
            r_state <= ST_RUNNING;
          end
          if (lap) begin
            r_lap_min   <= r_min;
            r_lap_sec   <= r_sec;
            r_lap_valid <= 1'b1;
          end
          if (load) begin
            r_min <= load_min;
            r_sec <= w_ld_sec;
          end
        end
        ST_EXPIRED: begin
          r_state <= ST_EXPIRED;
        end
      endcase
    end
  end

  assign minutes   = r_min;
  assign seconds   = r_sec;
  assign lap_min   = r_lap_min;
  assign lap_sec   = r_lap_sec;
  assign lap_valid = r_lap_valid;
  assign status    = r_state;
  assign expired   = r_expired;
  assign wrapped   = r_wrapped;

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Directed bench for stopwatch_timer_core.
// Instance a: TICK_DIV=1, MIN_W=2; instance b: TICK_DIV=4, MIN_W=8.
module tb_stopwatch_timer_core;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       mode = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_min = '0;
  logic [5:0] load_sec = '0;
  logic       lap = 1'b0;

  logic [1:0] a_min, a_lmin;
  logic [5:0] a_sec, a_lsec;
  logic       a_lv, a_exp, a_wrp;
  logic [1:0] a_st;

  logic [7:0] b_min, b_lmin;
  logic [5:0] b_sec, b_lsec;
  logic       b_lv, b_exp, b_wrp;
  logic [1:0] b_st;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  stopwatch_timer_core #(.TICK_DIV(1), .MIN_W(2)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .clear(clear), .mode(mode), .load(load),
    .load_min(load_min[1:0]), .load_sec(load_sec), .lap(lap),
    .minutes(a_min), .seconds(a_sec),
    .lap_min(a_lmin), .lap_sec(a_lsec), .lap_valid(a_lv),
    .status(a_st), .expired(a_exp), .wrapped(a_wrp)
  );

  stopwatch_timer_core #(.TICK_DIV(4), .MIN_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .clear(clear), .mode(mode), .load(load),
    .load_min(load_min), .load_sec(load_sec), .lap(lap),
    .minutes(b_min), .seconds(b_sec),
    .lap_min(b_lmin), .lap_sec(b_lsec), .lap_valid(b_lv),
    .status(b_st), .expired(b_exp), .wrapped(b_wrp)
  );

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 0; stop = 0; clear = 0; mode = 0;
    load = 0; load_min = 0; load_sec = 0; lap = 0;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (a_st !== 2'b00) begin
      bad++; $display("FAIL rst_status got=%0d want=0", a_st);
    end
    total++;
    if ({a_min, a_sec} !== 8'h00) begin
      bad++; $display("FAIL rst_time got=%0d:%0d want=0:0", a_min, a_sec);
    end
    total++;
    if ({a_lv, a_exp, a_wrp, a_lmin, a_lsec} !== 11'd0) begin
      bad++; $display("FAIL rst_misc got lv=%0d e=%0d w=%0d want 0", a_lv, a_exp, a_wrp);
    end
    total++;
    if ({b_st, b_min, b_sec, b_lv} !== 17'd0) begin
      bad++; $display("FAIL rst_b got st=%0d t=%0d:%0d want 0", b_st, b_min, b_sec);
    end
  endtask

  task automatic test_count_up();
    do_reset();
    mode = 0; start = 1; cyc(); start = 0;
    total++;
    if (a_st !== 2'b01 || a_sec !== 6'd0) begin
      bad++; $display("FAIL up_first got st=%0d s=%0d want st=1 s=0", a_st, a_sec);
    end
    cyc(61);
    total++;
    if (a_min !== 2'd1 || a_sec !== 6'd1 || a_st !== 2'b01) begin
      bad++; $display("FAIL up_61 got %0d:%0d st=%0d want 1:1 st=1", a_min, a_sec, a_st);
    end
    stop = 1; cyc(); stop = 0;
    total++;
    if (a_st !== 2'b10 || a_min !== 2'd1 || a_sec !== 6'd2) begin
      bad++; $display("FAIL up_stop got %0d:%0d st=%0d want 1:2 st=2", a_min, a_sec, a_st);
    end
    cyc(10);
    total++;
    if (a_st !== 2'b10 || a_min !== 2'd1 || a_sec !== 6'd2) begin
      bad++; $display("FAIL up_hold got %0d:%0d st=%0d want 1:2 st=2", a_min, a_sec, a_st);
    end
  endtask

  task automatic test_countdown();
    do_reset();
    load_min = 0; load_sec = 2; load = 1; cyc(); load = 0;
    total++;
    if (b_min !== 8'd0 || b_sec !== 6'd2 || b_st !== 2'b00) begin
      bad++; $display("FAIL dn_load got %0d:%0d st=%0d want 0:2 st=0", b_min, b_sec, b_st);
    end
    mode = 1; start = 1; cyc(); start = 0; mode = 0;
    cyc(3);
    total++;
    if (b_sec !== 6'd2 || b_st !== 2'b01) begin
      bad++; $display("FAIL dn_n4 got s=%0d st=%0d want s=2 st=1", b_sec, b_st);
    end
    cyc();
    total++;
    if (b_sec !== 6'd1) begin
      bad++; $display("FAIL dn_n5 got s=%0d want 1", b_sec);
    end
    cyc(3);
    total++;
    if (b_sec !== 6'd1 || b_exp !== 1'b0) begin
      bad++; $display("FAIL dn_n8 got s=%0d e=%0d want s=1 e=0", b_sec, b_exp);
    end
    cyc();
    total++;
    if (b_sec !== 6'd0 || b_min !== 8'd0 || b_exp !== 1'b1 || b_st !== 2'b11) begin
      bad++; $display("FAIL dn_n9 got %0d:%0d e=%0d st=%0d want 0:0 e=1 st=3", b_min, b_sec, b_exp, b_st);
    end
    cyc();
    total++;
    if (b_exp !== 1'b0 || b_st !== 2'b11 || b_sec !== 6'd0) begin
      bad++; $display("FAIL dn_pulse got e=%0d st=%0d s=%0d want e=0 st=3 s=0", b_exp, b_st, b_sec);
    end
    start = 1; cyc(); start = 0;
    total++;
    if (b_st !== 2'b11) begin
      bad++; $display("FAIL dn_start_ign got st=%0d want 3", b_st);
    end
    clear = 1; cyc(); clear = 0;
    total++;
    if (b_st !== 2'b00 || b_sec !== 6'd0) begin
      bad++; $display("FAIL dn_clear got st=%0d s=%0d want 0", b_st, b_sec);
    end
    mode = 1; start = 1; cyc(); start = 0; mode = 0;
    total++;
    if (b_st !== 2'b00) begin
      bad++; $display("FAIL dn_zero_start got st=%0d want 0", b_st);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    load_min = 3; load_sec = 58; load = 1; cyc(); load = 0;
    mode = 0; start = 1; cyc(); start = 0;
    cyc();
    total++;
    if (a_min !== 2'd3 || a_sec !== 6'd59 || a_wrp !== 1'b0) begin
      bad++; $display("FAIL wrap_359 got %0d:%0d w=%0d want 3:59 w=0", a_min, a_sec, a_wrp);
    end
    cyc();
    total++;
    if (a_min !== 2'd0 || a_sec !== 6'd0 || a_wrp !== 1'b1 || a_st !== 2'b01) begin
      bad++; $display("FAIL wrap_roll got %0d:%0d w=%0d st=%0d want 0:0 w=1 st=1", a_min, a_sec, a_wrp, a_st);
    end
    cyc();
    total++;
    if (a_sec !== 6'd1 || a_wrp !== 1'b0 || a_st !== 2'b01) begin
      bad++; $display("FAIL wrap_after got s=%0d w=%0d st=%0d want 1 0 1", a_sec, a_wrp, a_st);
    end
  endtask

  task automatic test_lap();
    do_reset();
    mode = 0; start = 1; cyc(); start = 0;
    cyc(5);
    total++;
    if (a_sec !== 6'd5) begin
      bad++; $display("FAIL lap_pre got s=%0d want 5", a_sec);
    end
    lap = 1; cyc(); lap = 0;
    total++;
    if (a_lsec !== 6'd5 || a_lmin !== 2'd0 || a_lv !== 1'b1 || a_sec !== 6'd6) begin
      bad++; $display("FAIL lap_cap got l=%0d:%0d v=%0d s=%0d want 0:5 v=1 s=6", a_lmin, a_lsec, a_lv, a_sec);
    end
    lap = 1; clear = 1; cyc(); lap = 0; clear = 0;
    total++;
    if (a_lv !== 1'b0 || a_lsec !== 6'd0 || a_sec !== 6'd0 || a_st !== 2'b00) begin
      bad++; $display("FAIL lap_clear got v=%0d l=%0d s=%0d st=%0d want 0", a_lv, a_lsec, a_sec, a_st);
    end
  endtask

  task automatic test_load();
    do_reset();
    load_min = 1; load_sec = 63; load = 1; cyc(); load = 0;
    total++;
    if (a_min !== 2'd1 || a_sec !== 6'd59) begin
      bad++; $display("FAIL ld_sat got %0d:%0d want 1:59", a_min, a_sec);
    end
    mode = 0; start = 1; cyc(); start = 0;
    load_min = 0; load_sec = 10; load = 1; cyc(); load = 0;
    total++;
    if (a_min !== 2'd2 || a_sec !== 6'd0) begin
      bad++; $display("FAIL ld_run got %0d:%0d want 2:0", a_min, a_sec);
    end
    start = 1; stop = 1; cyc(); start = 0; stop = 0;
    total++;
    if (a_st !== 2'b10 || a_sec !== 6'd1) begin
      bad++; $display("FAIL ld_ss got st=%0d s=%0d want st=2 s=1", a_st, a_sec);
    end
    load_min = 3; load_sec = 7; load = 1; cyc(); load = 0;
    total++;
    if (a_min !== 2'd3 || a_sec !== 6'd7 || a_st !== 2'b10) begin
      bad++; $display("FAIL ld_pause got %0d:%0d st=%0d want 3:7 st=2", a_min, a_sec, a_st);
    end
  endtask

  task automatic test_async_rst();
    do_reset();
    load_min = 1; load_sec = 28; load = 1; cyc(); load = 0;
    mode = 0; start = 1; cyc(); start = 0;
    cyc();
    lap = 1; cyc(); lap = 0;
    total++;
    if (a_min !== 2'd1 || a_sec !== 6'd30 || a_lsec !== 6'd29 || a_lv !== 1'b1) begin
      bad++; $display("FAIL ar_pre got %0d:%0d lap=%0d want 1:30 lap=29", a_min, a_sec, a_lsec);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({a_st, a_min, a_sec, a_lmin, a_lsec, a_lv} !== 19'd0) begin
      bad++; $display("FAIL ar_a got st=%0d t=%0d:%0d lv=%0d want 0", a_st, a_min, a_sec, a_lv);
    end
    total++;
    if ({b_st, b_min, b_sec, b_lv, b_exp, b_wrp} !== 18'd0) begin
      bad++; $display("FAIL ar_b got st=%0d t=%0d:%0d want 0", b_st, b_min, b_sec);
    end
    cyc();
    rst = 1'b0;
    cyc();
    total++;
    if (a_exp !== 1'b0 || a_wrp !== 1'b0 || a_st !== 2'b00) begin
      bad++; $display("FAIL ar_post got e=%0d w=%0d st=%0d want 0", a_exp, a_wrp, a_st);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_countdown();
    test_wrap();
    test_lap();
    test_load();
    test_async_rst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_timer_core.md
Name: stopwatch_timer_core

Overview:
- Parametrised successor of the basic stopwatch: a MM:SS up/down stopwatch-timer with an internal 1-second tick prescaler.
- Adds countdown mode with preset load, an expiry state, and a lap-capture register.
- Sits between the debounced button/command interface and the display driver.
- Single clock domain: all counting is derived from the prescaler terminal count, never from a second clock.

Parameters:
- TICK_DIV, 50_000_000, clk cycles per counted second; must be >= 1, and 1 means one second per clk (simulation).
- MIN_W, 8, minutes counter width; minutes range 0..2^MIN_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous and active-high; the single clock is clk.
- start  in  1  one-cycle command: begin or resume counting.
- stop  in  1  one-cycle command: pause.
- clear  in  1  one-cycle command: synchronous return to IDLE at 00:00.
- mode  in  1  0 = count up, 1 = count down; sampled only on IDLE->RUNNING.
- load  in  1  one-cycle command: preset the counters from load_min/load_sec.
- load_min  in  MIN_W  preset minutes.
- load_sec  in  6  preset seconds.
- lap  in  1  one-cycle command: capture the current time.
- minutes  out  MIN_W  current minutes.
- seconds  out  6  current seconds, 0..59.
- lap_min  out  MIN_W  captured minutes.
- lap_sec  out  6  captured seconds.
- lap_valid  out  1  lap registers hold a capture.
- status  out  2  FSM state encoding.
- expired  out  1  one-cycle pulse on countdown reaching 00:00.
- wrapped  out  1  one-cycle pulse on up-count rollover.

Behaviour:
- Reset (rst=1, async): state=IDLE, minutes=0, seconds=0, lap_min=0, lap_sec=0, lap_valid=0, expired=0, wrapped=0, prescaler=0, latched mode=up. All outputs are registered.
- States and status encoding: IDLE=2'b00, RUNNING=2'b01, PAUSED=2'b10, EXPIRED=2'b11.
- Command priority per cycle: clear > start > stop.
- clear in any state: next cycle IDLE, counters 00:00, prescaler 0, lap regs 0, lap_valid 0; a same-cycle load, lap or tick is discarded.
- IDLE + start -> RUNNING; latch mode; prescaler=0.
  - Exception: mode=1 with counters at 00:00 ignores start and stays IDLE.
- PAUSED + start -> RUNNING; prescaler resumes from its held value; latched mode unchanged.
- RUNNING + stop -> PAUSED; prescaler and counters hold.
- Start in RUNNING is a no-op, so start+stop together in RUNNING -> PAUSED.
- EXPIRED: start, stop, load and lap are ignored; only clear exits.
- Prescaler: counts 0..TICK_DIV-1 only while RUNNING. The tick is the cycle where prescaler==TICK_DIV-1 and state==RUNNING; prescaler wraps to 0 on the tick.
- Tick latency: start asserted in cycle N -> status=RUNNING visible at N+1 -> first count update visible at N+TICK_DIV+1.
- Up count, on tick:
  - seconds<59: seconds+1.
  - seconds==59: seconds=0 and minutes+1.
  - At (2^MIN_W-1):59: roll to 00:00, assert wrapped for 1 cycle, stay RUNNING.
- Down count, on tick:
  - seconds>0: seconds-1.
  - seconds==0: seconds=59 and minutes-1.
  - Transition into 00:00: state -> EXPIRED, expired pulses 1 cycle coincident with 00:00 becoming visible; counters hold at 00:00.
- load: accepted only in IDLE or PAUSED, otherwise ignored.
  - minutes<=load_min; seconds<=min(load_sec,59).
  - In PAUSED, load also zeroes the prescaler.
- lap: accepted in RUNNING or PAUSED.
  - Captures the minutes/seconds visible in that cycle, i.e. pre-tick values if a tick coincides.
  - Sets lap_valid=1; lap_valid holds until clear or rst.
  - lap in IDLE/EXPIRED is ignored.
- rst asserted mid-count: immediate async return to the reset values; no pulse outputs are generated.

Decomposition:
- Package stopwatch_pkg: state encodings (ST_IDLE, ST_RUNNING, ST_PAUSED, ST_EXPIRED), SEC_W=6, SEC_MAX=59, and a function for prescaler width = max(1, clog2(TICK_DIV)).
- Sub-module tick_prescaler (params TICK_DIV; ports clk, rst, en, clr, tick).
- FSM, counters and lap registers stay in stopwatch_timer_core.

Test Plan:
- TICK_DIV=1, mode=0, start, run 61 cycles -> minutes=1, seconds=1, status=01; stop -> status=10, values hold for 10 cycles.
- TICK_DIV=4, load 0:02 in IDLE, mode=1, start -> seconds=1 after 5 cycles, 00:00 after 9 cycles with expired=1 for one cycle and status=11; start ignored; clear -> status=00.
- MIN_W=2, TICK_DIV=1, load 3:58, mode=0, start -> after 2 ticks 00:00, wrapped=1 for one cycle, status remains 01.
- Running at 0:05, lap on the tick cycle -> lap_sec=5, lap_valid=1; clear in the same cycle as a lap -> lap_valid=0, 00:00.
- load_sec=63 in IDLE -> seconds=59; load while RUNNING -> no change; start+stop same cycle in RUNNING -> PAUSED.
- rst pulsed mid-run at 1:30 -> all outputs zero asynchronously; mode=1 start at 00:00 -> stays IDLE.
